// File: rtl/inst_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// The fetch walks four byte lanes (F0..F3) and then presents the word in HOLD.
package inst_fetch_pkg;

   localparam int          InstAddrW = 32;
   localparam int          InstW     = 32;
   localparam int          StallW    = 6;
   localparam int          StallIf   = 1;
   localparam logic [31:0] ZeroWord  = 32'h0000_0000;
   localparam logic        RstEnable = 1'b1;

   typedef enum logic [2:0] {
      IfIdle = 3'd0,
      IfF0   = 3'd1,
      IfF1   = 3'd2,
      IfF2   = 3'd3,
      IfF3   = 3'd4,
      IfHold = 3'd5
   } if_state_t;

   // Byte lane (and address offset from pc) served by a fetch state.
   function automatic logic [1:0] laneOf(if_state_t s);
      logic [1:0] lane;
      lane = 2'd0;
      case (s)
         IfF1:    lane = 2'd1;
         IfF2:    lane = 2'd2;
         IfF3:    lane = 2'd3;
         default: lane = 2'd0;
      endcase
      return lane;
   endfunction

endpackage

// File: rtl/inst_fetch.sv
// IF stage: fetches each 32-bit instruction as four little-endian byte reads,
// stalls the pipeline while fetching and accepts branch/jump redirects from EX.
module inst_fetch
   import inst_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall_i,
   input  logic        branch_en_i,
   input  logic [31:0] branch_target_i,
   input  logic        mem_ack_i,
   input  logic [7:0]  mem_data_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o,
   output logic        stallreq_o
);

   if_state_t   state, state_d;
   logic [31:0] pc, pc_d;
   logic [23:0] ibuf, ibuf_d;
   logic [31:0] inst_q, inst_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         state  <= IfIdle;
         pc     <= ZeroWord;
         ibuf   <= 24'h0;
         inst_q <= ZeroWord;
      end else begin
         state  <= state_d;
         pc     <= pc_d;
         ibuf   <= ibuf_d;
         inst_q <= inst_d;
      end
   end

   // Request outputs depend only on state and pc, never on mem_ack_i.
   always_comb begin
      state_d    = state;
      pc_d       = pc;
      ibuf_d     = ibuf;
      inst_d     = inst_q;
      mem_req_o  = 1'b0;
      mem_addr_o = ZeroWord;
      stallreq_o = 1'b0;
      if_pc_o    = pc;
      if_inst_o  = ZeroWord;

      case (state)
         IfIdle: begin
            if_pc_o = ZeroWord;
            state_d = IfF0;
         end
         IfF0, IfF1, IfF2, IfF3: begin
            mem_req_o  = 1'b1;
            stallreq_o = 1'b1;
            mem_addr_o = pc + 32'(laneOf(state));
            if (mem_ack_i) begin
               case (state)
                  IfF0: begin
                     ibuf_d[7:0] = mem_data_i;
                     state_d     = IfF1;
                  end
                  IfF1: begin
                     ibuf_d[15:8] = mem_data_i;
                     state_d      = IfF2;
                  end
                  IfF2: begin
                     ibuf_d[23:16] = mem_data_i;
                     state_d       = IfF3;
                  end
                  default: begin
                     inst_d  = {mem_data_i, ibuf};
                     state_d = IfHold;
                  end
               endcase
            end
         end
         IfHold: begin
            if_inst_o = inst_q;
            if (!stall_i[StallIf]) begin
               pc_d    = pc + 32'd4;
               state_d = IfF0;
            end
         end
         default: state_d = IfIdle;
      endcase

      // A redirect overrides stall, ack and the HOLD advance; partial lanes are dropped.
      if (branch_en_i && (state != IfIdle)) begin
         pc_d    = {branch_target_i[31:2], 2'b00};
         state_d = IfF0;
         ibuf_d  = ibuf;
         inst_d  = inst_q;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by random
// ack/stall/redirect traffic, compared against a byte-count reference model.
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic [5:0]  stall_i;
   logic        branch_en_i;
   logic [31:0] branch_target_i;
   logic        mem_ack_i;
   logic [7:0]  mem_data_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        stallreq_o;

   int errorCount;
   int checkCount;

   // Reference model: -1 means the reset idle cycle, 0..3 bytes received, 4 means holding a word.
   int          expCount;
   logic [31:0] expPc;

   inst_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .branch_en_i     (branch_en_i),
      .branch_target_i (branch_target_i),
      .mem_ack_i       (mem_ack_i),
      .mem_data_i      (mem_data_i),
      .mem_req_o       (mem_req_o),
      .mem_addr_o      (mem_addr_o),
      .if_pc_o         (if_pc_o),
      .if_inst_o       (if_inst_o),
      .stallreq_o      (stallreq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte-wide memory image: a small program at 0..3, hashed contents elsewhere.
   function automatic logic [7:0] byteAt(logic [31:0] a);
      logic [31:0] h;
      case (a)
         32'd0:   return 8'h13;
         32'd1:   return 8'h05;
         32'd2:   return 8'h10;
         32'd3:   return 8'h00;
         default: begin
            h = a * 32'd2654435761;
            return h[31:24] ^ a[7:0];
         end
      endcase
   endfunction

   function automatic logic [31:0] wordAt(logic [31:0] a);
      return {byteAt(a + 32'd3), byteAt(a + 32'd2), byteAt(a + 32'd1), byteAt(a)};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkAll();
      logic fetching;
      fetching = (expCount >= 0) && (expCount < 4);
      checkOutput("mem_req", 32'(mem_req_o), 32'(fetching));
      checkOutput("stallreq", 32'(stallreq_o), 32'(fetching));
      if (fetching)
         checkOutput("mem_addr", mem_addr_o, expPc + 32'(expCount));
      checkOutput("if_pc", if_pc_o, (expCount < 0) ? 32'h0 : expPc);
      checkOutput("if_inst", if_inst_o, (expCount == 4) ? wordAt(expPc) : 32'h0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_req"}, 32'(mem_req_o), 32'h0);
      checkOutput({tag, "_addr"}, mem_addr_o, 32'h0);
      checkOutput({tag, "_stallreq"}, 32'(stallreq_o), 32'h0);
      checkOutput({tag, "_pc"}, if_pc_o, 32'h0);
      checkOutput({tag, "_inst"}, if_inst_o, 32'h0);
   endtask

   task automatic modelUpdate(input logic ack, input logic stl, input logic br, input logic [31:0] tgt);
      if (expCount < 0) begin
         expCount = 0;
      end else if (br) begin
         expPc    = tgt & 32'hFFFF_FFFC;
         expCount = 0;
      end else if (expCount < 4) begin
         if (ack) expCount++;
      end else if (!stl) begin
         expPc    = expPc + 32'd4;
         expCount = 0;
      end
   endtask

   // One cycle: check settled outputs at the falling edge, drive inputs, advance the model.
   task automatic applyStimulus(input logic ack, input logic stl, input logic br, input logic [31:0] tgt);
      checkAll();
      mem_ack_i       = ack;
      mem_data_i      = ack ? byteAt(mem_addr_o) : 8'hxx;
      stall_i         = stl ? 6'b000111 : 6'b000000;
      branch_en_i     = br;
      branch_target_i = tgt;
      @(posedge clk);
      modelUpdate(ack, stl, br, tgt);
      @(negedge clk);
   endtask

   initial begin
      errorCount      = 0;
      checkCount      = 0;
      rst             = 1'b1;
      stall_i         = 6'b0;
      branch_en_i     = 1'b0;
      branch_target_i = 32'h0;
      mem_ack_i       = 1'b0;
      mem_data_i      = 8'h0;
      expCount        = -1;
      expPc           = 32'h0;

      repeat (2) @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b0;

      // Idle cycle, then four acked byte reads at 0..3.
      repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("first_inst", if_inst_o, 32'h0010_0513);
      checkOutput("first_pc", if_pc_o, 32'h0);

      // Hold under stall, then release to pc+4.
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("release_addr", mem_addr_o, 32'h4);
      checkOutput("release_pc", if_pc_o, 32'h4);

      // Ack withheld for two cycles in F1.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("f1_addr_held", mem_addr_o, 32'h5);
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("slow_inst", if_inst_o, {byteAt(32'd7), byteAt(32'd6), byteAt(32'd5), byteAt(32'd4)});
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

      // Redirect in F2 coinciding with an ack.
      repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h103);
      checkOutput("redir_addr", mem_addr_o, 32'h100);
      repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("redir_inst", if_inst_o, wordAt(32'h100));

      // Redirect in HOLD beats the pc+4 advance.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h200);
      checkOutput("hold_redir_pc", if_pc_o, 32'h200);

      // Asynchronous reset between edges during F3.
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("f3_addr", mem_addr_o, 32'h203);
      mem_ack_i   = 1'b0;
      branch_en_i = 1'b0;
      #2 rst = 1'b1;
      #1 checkResetOutputs("async");
      #1 rst = 1'b0;
      expCount = -1;
      expPc    = 32'h0;
      @(posedge clk);
      modelUpdate(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("restart_addr", mem_addr_o, 32'h0);

      // Random traffic, with some redirects near the top of the address space.
      for (int i = 0; i < 3000; i++) begin
         logic        ack, stl, br;
         logic [31:0] tgt;
         ack = ($urandom_range(0, 3) != 0);
         stl = ($urandom_range(0, 2) == 0);
         br  = ($urandom_range(0, 15) == 0);
         tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         applyStimulus(ack, stl, br, tgt);
      end
      checkAll();

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
